// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer: fetches over req/ack, resolves branches locally, issues the rest to decode.
// Optional macro PC_SEQ_FLAG_BYPASS_EN forwards same-cycle flag writes into the branch condition.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr,
    input  logic        instr_ready,
    input  logic        flags_we,
    input  logic [3:0]  flags_in,
    input  logic        flags_busy,
    output logic [15:0] pc,
    output logic [3:0]  stored_flags,
    output logic        branch_taken,
    output logic        halted
);

    localparam int unsigned PC_W = 16;

    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_BRZ  = 4'b1010;
    localparam logic [3:0] OP_BRNZ = 4'b1011;
    localparam logic [3:0] OP_BRNS = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_BRANCH,
        S_HALTED
    } state_t;

    state_t state;

    logic [3:0]      fetch_op;
    logic            fetch_is_branch;
    logic [3:0]      cond_flags;
    logic            take_c;
    logic [PC_W-1:0] offset;

    assign imem_addr = pc;
    assign fetch_op  = imem_rdata[15:12];
    assign offset    = {{4{instr[11]}}, instr[11:0]};

    assign fetch_is_branch = (fetch_op == OP_JMP) || (fetch_op == OP_BRZ) ||
                             (fetch_op == OP_BRNZ) || (fetch_op == OP_BRNS);

    // Branch condition evaluated from the held instruction word
    always_comb begin
        cond_flags = stored_flags;
`ifdef PC_SEQ_FLAG_BYPASS_EN
        if (flags_we) begin
            cond_flags = flags_in;
        end
`endif
        take_c = 1'b0;
        case (instr[15:12])
            OP_JMP:  take_c = 1'b1;
            OP_BRZ:  take_c = cond_flags[0];
            OP_BRNZ: take_c = ~cond_flags[0];
            OP_BRNS: take_c = ~cond_flags[1];
            default: take_c = 1'b0;
        endcase
    end

    // Sequencer FSM; strobes are registered alongside the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            stored_flags <= 4'h0;
            instr        <= 16'h0000;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            branch_taken <= 1'b0;
            halted       <= 1'b0;
        end else begin
            if (flags_we) begin
                stored_flags <= flags_in;
            end
            branch_taken <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        if (fetch_op == OP_HALT) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else if (fetch_is_branch) begin
                            state <= S_BRANCH;
                        end else begin
                            state       <= S_ISSUE;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + PC_W'(1);
                        state       <= S_FETCH;
                        imem_req    <= 1'b1;
                    end
                end
                S_BRANCH: begin
                    // Pulse lands in the cycle the redirected pc becomes visible
                    if (!flags_busy) begin
                        pc           <= take_c ? (pc + offset) : (pc + PC_W'(1));
                        branch_taken <= take_c;
                        state        <= S_FETCH;
                        imem_req     <= 1'b1;
                    end
                end
                S_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: ISA-level reference model checked every cycle plus directed literal checks.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        flags_we;
    logic [3:0]  flags_in;
    logic        flags_busy;
    logic [15:0] pc;
    logic [3:0]  stored_flags;
    logic        branch_taken;
    logic        halted;

    logic [15:0] mem [0:65535];
    logic        ack_en;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = mem[imem_addr];

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .flags_we     (flags_we),
        .flags_in     (flags_in),
        .flags_busy   (flags_busy),
        .pc           (pc),
        .stored_flags (stored_flags),
        .branch_taken (branch_taken),
        .halted       (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: what the core must be doing this cycle, in instruction-level terms
    localparam int P_IDLE   = 0;
    localparam int P_FETCH  = 1;
    localparam int P_ISSUE  = 2;
    localparam int P_BRANCH = 3;
    localparam int P_HALTED = 4;

    int          m_phase;
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [3:0]  m_flags;
    logic        m_bt;
    logic [3:0]  m_fsel;
    logic        m_take;
    int          m_ofs;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_pc",     32'(pc),           32'(16'h0000));
            chk("rst_req",    32'(imem_req),     32'(0));
            chk("rst_valid",  32'(instr_valid),  32'(0));
            chk("rst_bt",     32'(branch_taken), 32'(0));
            chk("rst_halted", 32'(halted),       32'(0));
            chk("rst_instr",  32'(instr),        32'(0));
            chk("rst_flags",  32'(stored_flags), 32'(0));
            m_phase = P_IDLE;
            m_pc    = 16'h0000;
            m_instr = 16'h0000;
            m_flags = 4'h0;
            m_bt    = 1'b0;
        end else begin
            chk("m_req",    32'(imem_req),     32'(m_phase == P_FETCH));
            chk("m_valid",  32'(instr_valid),  32'(m_phase == P_ISSUE));
            chk("m_halted", 32'(halted),       32'(m_phase == P_HALTED));
            chk("m_pc",     32'(pc),           32'(m_pc));
            chk("m_instr",  32'(instr),        32'(m_instr));
            chk("m_flags",  32'(stored_flags), 32'(m_flags));
            chk("m_bt",     32'(branch_taken), 32'(m_bt));
            if (imem_req) begin
                chk("m_addr", 32'(imem_addr), 32'(m_pc));
            end

            // Advance the model across the coming rising edge
            m_bt = 1'b0;
            case (m_phase)
                P_IDLE: if (run) m_phase = P_FETCH;
                P_FETCH: begin
                    if (imem_ack) begin
                        m_instr = imem_rdata;
                        case (imem_rdata[15:12])
                            4'h9, 4'hA, 4'hB, 4'hC: m_phase = P_BRANCH;
                            4'hF:                   m_phase = P_HALTED;
                            default:                m_phase = P_ISSUE;
                        endcase
                    end
                end
                P_ISSUE: begin
                    if (instr_ready) begin
                        m_pc    = m_pc + 16'd1;
                        m_phase = P_FETCH;
                    end
                end
                P_BRANCH: begin
                    if (!flags_busy) begin
`ifdef PC_SEQ_FLAG_BYPASS_EN
                        m_fsel = flags_we ? flags_in : m_flags;
`else
                        m_fsel = m_flags;
`endif
                        case (m_instr[15:12])
                            4'h9:    m_take = 1'b1;
                            4'hA:    m_take = m_fsel[0];
                            4'hB:    m_take = !m_fsel[0];
                            default: m_take = !m_fsel[1];
                        endcase
                        m_ofs   = $signed(m_instr[11:0]);
                        m_pc    = m_take ? 16'(int'(m_pc) + m_ofs) : m_pc + 16'd1;
                        m_bt    = m_take;
                        m_phase = P_FETCH;
                    end
                end
                default: ;
            endcase
            if (flags_we) m_flags = flags_in;
        end
    end

    initial begin
        rst_n       = 1'b0;
        run         = 1'b0;
        ack_en      = 1'b1;
        instr_ready = 1'b1;
        flags_we    = 1'b0;
        flags_in    = 4'h0;
        flags_busy  = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h1000;
        mem[5]        = 16'hAFFE;
        mem[6]        = 16'h9FF9;
        mem[16'hFFFF] = 16'h9002;
        mem[16'h0012] = 16'hA004;

        step(5);
        chk("reset_pc",     32'(pc),       32'(16'h0000));
        chk("reset_req",    32'(imem_req), 32'(0));
        chk("reset_halted", 32'(halted),   32'(0));
        rst_n = 1'b1;
        step(2);
        chk("idle_no_run", 32'(imem_req), 32'(0));
        run = 1'b1;
        step(1);
        chk("start_req",  32'(imem_req),  32'(1));
        chk("start_addr", 32'(imem_addr), 32'(16'h0000));
        run = 1'b0;

        // Three normal instructions at two cycles each
        step(6);
        chk("seq_pc3", 32'(pc), 32'(16'h0003));
        flags_we = 1'b1;
        flags_in = 4'b0001;
        step(1);
        flags_we = 1'b0;
        step(4);
        chk("brz_pc5",    32'(pc),          32'(16'h0005));
        chk("brz_hidden", 32'(instr_valid), 32'(0));
        chk("brz_instr",  32'(instr),       32'(16'hAFFE));
        step(1);
        chk("brz_target", 32'(pc),           32'(16'h0003));
        chk("brz_pulse",  32'(branch_taken), 32'(1));
        mem[5] = 16'hBFFE;
        step(1);
        chk("brz_pulse_end", 32'(branch_taken), 32'(0));
        step(4);
        chk("brnz_hidden", 32'(instr_valid), 32'(0));
        step(1);
        chk("brnz_fallthru", 32'(pc),           32'(16'h0006));
        chk("brnz_no_pulse", 32'(branch_taken), 32'(0));

        // Jump to the top of memory, then a wrapping jump
        mem[1]   = 16'hC00A;
        flags_we = 1'b1;
        flags_in = 4'b0011;
        step(1);
        flags_we = 1'b0;
        step(1);
        chk("jmp_ffff",      32'(pc),           32'(16'hFFFF));
        chk("jmp_ffff_addr", 32'(imem_addr),    32'(16'hFFFF));
        chk("jmp_pulse",     32'(branch_taken), 32'(1));
        step(2);
        chk("jmp_wrap", 32'(pc), 32'(16'h0001));
        mem[2] = 16'hA010;
        step(2);
        chk("brns_not_taken", 32'(pc),           32'(16'h0002));
        chk("brns_no_pulse",  32'(branch_taken), 32'(0));

        // Branch stalled on busy flags for three cycles
        flags_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("busy_hold_pc", 32'(pc), 32'(16'h0002));
        end
        step(1);
        chk("busy_cycle4_pc", 32'(pc), 32'(16'h0002));
        flags_busy = 1'b0;
        step(1);
        chk("busy_resolved", 32'(pc),           32'(16'h0012));
        chk("busy_pulse",    32'(branch_taken), 32'(1));

        // Flag write coinciding with branch resolution
        flags_we = 1'b1;
        flags_in = 4'b0000;
        step(1);
        flags_in = 4'b0001;
        step(1);
        flags_we = 1'b0;
        chk("bypass_flags", 32'(stored_flags), 32'(4'b0001));
`ifdef PC_SEQ_FLAG_BYPASS_EN
        chk("bypass_pc",    32'(pc),           32'(16'h0016));
        chk("bypass_pulse", 32'(branch_taken), 32'(1));
`else
        chk("nobypass_pc",    32'(pc),           32'(16'h0013));
        chk("nobypass_pulse", 32'(branch_taken), 32'(0));
`endif

        // Async reset while a fetch is waiting for ack
        ack_en = 1'b0;
        step(1);
        chk("stall_req", 32'(imem_req), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req", 32'(imem_req), 32'(0));
        chk("async_pc",  32'(pc),       32'(16'h0000));

        // Halt and stay halted
        mem[0] = 16'hF000;
        ack_en = 1'b1;
        run    = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("halt_fetch_req",  32'(imem_req),  32'(1));
        chk("halt_fetch_addr", 32'(imem_addr), 32'(16'h0000));
        step(1);
        chk("halted", 32'(halted),   32'(1));
        chk("halt_instr", 32'(instr), 32'(16'hF000));
        run      = 1'b0;
        flags_we = 1'b1;
        flags_in = 4'b0110;
        step(1);
        flags_we = 1'b0;
        chk("halt_flag_write", 32'(stored_flags), 32'(4'b0110));
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("halt_no_req", 32'(imem_req), 32'(0));
            chk("halt_pc",     32'(pc),       32'(16'h0000));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
